keypad_debouncer: RTL and testbench

//   Front end for the 12-key pad. Synchronises the raw BTN1..BTN9, BTN_star, BTN_0, BTN_sharp lines and debounces each key.

---
 rtl/keypad_debouncer.sv | 138 +++++++++++++
 tb/tb_keypad_debouncer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: 2-FF synchroniser and per-key debounce for the 12-key pad.
// Produces a debounced level vector, one-cycle press and release pulses, and
// any-key / single-key flags.
// Optional auto-repeat of a single held key is compiled in when KEY_REPEAT_EN
// is defined. Without that macro, Kpress fires only on accepted edges.
module keypad_debouncer #(
   parameter int N_KEYS       = 12,
   parameter int CNT_W        = 16,
   parameter int DB_CYCLES    = 50000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_KEYS-1:0] Kin,
   output logic [N_KEYS-1:0] Kstate,
   output logic [N_KEYS-1:0] Kpress,
   output logic [N_KEYS-1:0] Krel,
   output logic              Kany,
   output logic              Kvalid
);

   if (DB_CYCLES < 1 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db
      $error("keypad_debouncer: DB_CYCLES out of range for CNT_W");
   end
   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
      $error("keypad_debouncer: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N_KEYS-1:0] sync1;
   logic [N_KEYS-1:0] ks;
   logic [CNT_W-1:0]  cnt     [N_KEYS];
   logic [CNT_W-1:0]  cnt_nxt [N_KEYS];
   logic [N_KEYS-1:0] kstate_nxt;
   logic [N_KEYS-1:0] press_edge;
   logic [N_KEYS-1:0] rel_edge;
   logic [N_KEYS-1:0] press_nxt;

   // Per-key stability counter; a change is accepted after DB_CYCLES differing samples.
   always_comb begin
      kstate_nxt = Kstate;
      press_edge = '0;
      rel_edge   = '0;
      for (int unsigned i = 0; i < unsigned'(N_KEYS); i++) begin
         cnt_nxt[i] = cnt[i];
         if (ks[i] == Kstate[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            cnt_nxt[i]    = '0;
            kstate_nxt[i] = ks[i];
            press_edge[i] = ks[i];
            rel_edge[i]   = ~ks[i];
         end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RCNT_W  = $clog2(REP_MAX + 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

   typedef enum logic {R_DELAY, R_RATE} rep_state_t;

   rep_state_t        rstate, rstate_nxt;
   logic [RCNT_W-1:0] rcnt, rcnt_nxt;
   logic              rep_fire;

   // Repeat phase register: initial delay, then the steady repeat rate.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rstate <= R_DELAY;
         rcnt   <= '0;
      end else begin
         rstate <= rstate_nxt;
         rcnt   <= rcnt_nxt;
      end
   end

   // Repeat timing runs only while a single key is held and Kstate is unchanged.
   always_comb begin
      rstate_nxt = rstate;
      rcnt_nxt   = rcnt;
      rep_fire   = 1'b0;
      if (!Kvalid || (kstate_nxt != Kstate)) begin
         rstate_nxt = R_DELAY;
         rcnt_nxt   = '0;
      end else if (rstate == R_DELAY && rcnt == DELAY_LAST) begin
         rep_fire   = 1'b1;
         rstate_nxt = R_RATE;
         rcnt_nxt   = '0;
      end else if (rstate == R_RATE && rcnt == RATE_LAST) begin
         rep_fire   = 1'b1;
         rcnt_nxt   = '0;
      end else begin
         rcnt_nxt = rcnt + RCNT_W'(1);
      end
      press_nxt = press_edge | (rep_fire ? Kstate : '0);
   end
`else
   // Press pulses come only from accepted edges.
   always_comb begin
      press_nxt = press_edge;
   end
`endif

   // Synchroniser, debounce state and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync1  <= '0;
         ks     <= '0;
         Kstate <= '0;
         Kpress <= '0;
         Krel   <= '0;
         Kany   <= 1'b0;
         Kvalid <= 1'b0;
         for (int unsigned i = 0; i < unsigned'(N_KEYS); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1  <= Kin;
         ks     <= sync1;
         Kstate <= kstate_nxt;
         Kpress <= press_nxt;
         Krel   <= rel_edge;
         Kany   <= |kstate_nxt;
         Kvalid <= $onehot(kstate_nxt);
         for (int unsigned i = 0; i < unsigned'(N_KEYS); i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: randomized stimulus with a scoreboard.
// The reference model decides each key's acceptance from the window of
// recently sampled raw inputs. Its expected outputs are queued every edge,
// and a monitor compares them against the DUT on the falling edge.
// Define KEY_REPEAT_EN for both bench and RTL to check auto-repeat.
module tb_keypad_debouncer;

   localparam int NK = 12;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [NK-1:0] Kin = '0;
   logic [NK-1:0] Kstate, Kpress, Krel;
   logic          Kany, Kvalid;

   keypad_debouncer #(
      .N_KEYS(NK), .CNT_W(16), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .CLK(CLK), .RST(RST), .Kin(Kin), .Kstate(Kstate), .Kpress(Kpress),
      .Krel(Krel), .Kany(Kany), .Kvalid(Kvalid)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [NK-1:0] st;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
      logic          any;
      logic          vld;
   } exp_t;

   exp_t          sb[$];
   logic [NK-1:0] hist[$];
   logic [NK-1:0] m_state = '0;
   int            since_change = 0;
   int            errors = 0;
   int            checks = 0;

   // Reference model: a key flips once its last DB synchronised samples all differ from it.
   always @(posedge CLK) begin : model
      exp_t          e;
      logic [NK-1:0] nst, pr, rl;
      int            k, m;
      bit            stable;
      if (!RST) begin
         hist.delete();
         m_state      = '0;
         since_change = 0;
         e            = '0;
      end else begin
         hist.push_back(Kin);
         k   = hist.size() - 1;
         nst = m_state;
         for (int i = 0; i < NK; i++) begin
            stable = 1'b1;
            for (int j = 0; j < DB; j++) begin
               m = k - j;
               if (m < 2) stable = 1'b0;
               else if (hist[m-2][i] == m_state[i]) stable = 1'b0;
            end
            if (stable) nst[i] = ~m_state[i];
         end
         pr = nst & ~m_state;
         rl = m_state & ~nst;
`ifdef KEY_REPEAT_EN
         if (nst != m_state) since_change = 0;
         else since_change++;
         if (nst == m_state && $countones(m_state) == 1 &&
             (since_change == RD || (since_change > RD && (since_change - RD) % RR == 0)))
            pr = pr | m_state;
`endif
         m_state = nst;
         e.st  = nst;
         e.pr  = pr;
         e.rl  = rl;
         e.any = (nst != '0);
         e.vld = ($countones(nst) == 1);
      end
      sb.push_back(e);
   end

   task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: pop one expected set per edge and compare away from the active edge.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("Kstate", Kstate, e.st);
         chk("Kpress", Kpress, e.pr);
         chk("Krel",   Krel,   e.rl);
         chk("Kany",   {{(NK-1){1'b0}}, Kany},   {{(NK-1){1'b0}}, e.any});
         chk("Kvalid", {{(NK-1){1'b0}}, Kvalid}, {{(NK-1){1'b0}}, e.vld});
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      int r, len, sel;
      // Reset with all keys pressed, then release.
      RST = 1'b0;
      Kin = '1;
      hold(3);
      RST = 1'b1;
      hold(12);
      // Single key press and release.
      Kin = '0;           hold(10);
      Kin = 12'h010;      hold(10);
      Kin = '0;           hold(10);
      // Bouncing key 0, then settled high.
      Kin = 12'h001;      hold(1);
      Kin = 12'h000;      hold(1);
      Kin = 12'h001;      hold(1);
      Kin = 12'h000;      hold(1);
      Kin = 12'h001;      hold(10);
      Kin = '0;           hold(10);
      // Chord of keys 1 and 10, then drop key 10.
      Kin = 12'h402;      hold(10);
      Kin = 12'h002;      hold(10);
      Kin = '0;           hold(10);
      // Reset pulse mid-hold.
      Kin = 12'h008;      hold(8);
      RST = 1'b0;         hold(1);
      RST = 1'b1;         hold(10);
      Kin = '0;           hold(10);
      // Long single-key hold, then a second key joins.
      Kin = 12'h080;      hold(60);
      Kin = 12'h180;      hold(30);
      Kin = '0;           hold(10);
      // Randomized segments around the debounce threshold.
      repeat (400) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            RST = 1'b0;
            hold($urandom_range(1, 2));
            RST = 1'b1;
         end else if (r < 70) begin
            Kin = Kin ^ (NK'(1) << $urandom_range(0, NK-1));
         end else if (r < 85) begin
            Kin = Kin ^ NK'($urandom);
         end else if (r < 95) begin
            Kin = NK'(1) << $urandom_range(0, NK-1);
         end else begin
            Kin = '0;
         end
         sel = $urandom_range(0, 9);
         if (sel < 6) len = $urandom_range(1, DB + 1);
         else if (sel < 9) len = $urandom_range(DB + 2, 12);
         else len = $urandom_range(20, 45);
         hold(len);
      end
      Kin = '0;
      hold(12);
      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
